// File: rtl/audio_stream_player_pkg.sv
// Shared types for the audio stream player: the playback FSM state encoding.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } player_state_e;

endpackage

// File: rtl/audio_stream_player_flash_read_ctrl.sv
// Avalon-MM read sequencer: one read in flight, holds request through waitrequest,
// and swallows the data of a read that was in flight when the player restarted.
module flash_read_ctrl #(
    parameter int                ADDR_W   = 23,
    parameter int                WORD_W   = 32,
    parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    output logic              busy,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic              flash_waitrequest,
    input  logic              flash_readdatavalid,
    input  logic [WORD_W-1:0] flash_readdata
);

    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic              disc_q, disc_d;
    logic              rdv;

    // Data strobes are only meaningful once our request has been accepted.
    assign rdv        = flash_readdatavalid && pend_q;
    assign busy       = rd_q || pend_q;
    assign word_valid = rdv && !disc_q && !flush;
    assign word       = flash_readdata;
    assign flash_read = rd_q;
    assign flash_addr = addr_q;

    always_comb begin
        rd_d   = rd_q;
        addr_d = addr_q;
        pend_d = pend_q;
        disc_d = disc_q;
        if (rd_q && !flash_waitrequest) begin
            rd_d   = 1'b0;
            pend_d = 1'b1;
        end else if (req && !busy) begin
            rd_d   = 1'b1;
            addr_d = addr;
        end
        if (rdv) begin
            pend_d = 1'b0;
            disc_d = 1'b0;
        end
        // A request still stalled cannot be withdrawn, so its data is dropped later.
        if (flush && (rd_q || (pend_q && !flash_readdatavalid))) begin
            disc_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= 1'b0;
            addr_q <= RST_ADDR;
            pend_q <= 1'b0;
            disc_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            addr_q <= addr_d;
            pend_q <= pend_d;
            disc_q <= disc_d;
        end
    end

endmodule

// File: rtl/audio_stream_player.sv
// Flash-to-codec sample engine: double-buffered word prefetch, per-tick unpacking,
// forward/reverse playback with optional looping over a fixed address window.
module audio_stream_player
    import audio_pkg::*;
#(
    parameter int                SAMPLE_W   = 16,
    parameter int                SPW        = 2,
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'('h7FFFF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_tick,
    input  logic                    start,
    input  logic                    play,
    input  logic                    forward,
    input  logic                    loop,
    output logic                    flash_read,
    output logic [ADDR_W-1:0]       flash_addr,
    input  logic                    flash_waitrequest,
    input  logic                    flash_readdatavalid,
    input  logic [SAMPLE_W*SPW-1:0] flash_readdata,
    output logic [SAMPLE_W-1:0]     audio_sample,
    output logic                    sample_valid,
    output logic                    finished,
    output logic [7:0]              underrun_count
);

    localparam int               WORD_W   = SAMPLE_W * SPW;
    localparam int               IDX_W    = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPW - 1);

    player_state_e state_q, state_d;

    logic [WORD_W-1:0]   cur_q, cur_d, nxt_q, nxt_d;
    logic                cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
    logic                cur_rev_q, cur_rev_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                ptr_end_q, ptr_end_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                svld_q, svld_d;
    logic                fin_q, fin_d;
    logic [7:0]          urun_q, urun_d;

    logic                           fetch_req, rd_busy, word_valid;
    logic [WORD_W-1:0]              word;
    logic [SPW-1:0][SAMPLE_W-1:0]   cur_slices;
    logic [IDX_W-1:0]               sel;
    logic                           fire, starve, consume;

    flash_read_ctrl #(
        .ADDR_W   (ADDR_W),
        .WORD_W   (WORD_W),
        .RST_ADDR (START_ADDR)
    ) u_rd (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req                 (fetch_req),
        .addr                (ptr_q),
        .flush               (start),
        .busy                (rd_busy),
        .word_valid          (word_valid),
        .word                (word),
        .flash_read          (flash_read),
        .flash_addr          (flash_addr),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdatavalid (flash_readdatavalid),
        .flash_readdata      (flash_readdata)
    );

    assign cur_slices = cur_q;
    assign sel        = cur_rev_q ? (LAST_IDX - idx_q) : idx_q;

    assign fetch_req = ((state_q == FETCH) || (state_q == PLAY)) && !nxt_vld_q
                       && !rd_busy && !ptr_end_q && !start;
    assign fire      = sample_tick && play && !start && (state_q == PLAY) && cur_vld_q;
    assign starve    = sample_tick && play && !start && (state_q == PLAY) && !cur_vld_q;
    assign consume   = fire && (idx_q == LAST_IDX);

    // Wrap decisions compare against the edge before stepping, so no overflow.
    always_comb begin
        ptr_d     = ptr_q;
        ptr_end_d = ptr_end_q;
        if (start) begin
            ptr_d     = forward ? START_ADDR : END_ADDR;
            ptr_end_d = 1'b0;
        end else if (fetch_req) begin
            if (forward) begin
                if (ptr_q == END_ADDR) begin
                    if (loop) ptr_d = START_ADDR;
                    else      ptr_end_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end else begin
                if (ptr_q == START_ADDR) begin
                    if (loop) ptr_d = END_ADDR;
                    else      ptr_end_d = 1'b1;
                end else begin
                    ptr_d = ptr_q - ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        cur_vld_d = cur_vld_q;
        cur_rev_d = cur_rev_q;
        nxt_d     = nxt_q;
        nxt_vld_d = nxt_vld_q;
        idx_d     = idx_q;
        sample_d  = sample_q;
        svld_d    = 1'b0;
        fin_d     = fin_q;
        urun_d    = urun_q;

        if (fire) begin
            sample_d = cur_slices[sel];
            svld_d   = 1'b1;
            idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
        if (consume) begin
            cur_d     = nxt_q;
            cur_vld_d = nxt_vld_q;
            cur_rev_d = !forward;
            nxt_vld_d = 1'b0;
        end
        // Unpack order is latched whenever a word becomes the current word.
        if (word_valid) begin
            if (!cur_vld_d) begin
                cur_d     = word;
                cur_vld_d = 1'b1;
                cur_rev_d = !forward;
            end else begin
                nxt_d     = word;
                nxt_vld_d = 1'b1;
            end
        end
        if (starve && (urun_q != 8'hFF)) begin
            urun_d = urun_q + 8'd1;
        end

        case (state_q)
            FETCH: if (cur_vld_d) state_d = PLAY;
            PLAY: begin
                if (consume && !nxt_vld_q && ptr_end_q && !rd_busy) begin
                    fin_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: ;
        endcase

        if (start) begin
            state_d   = FETCH;
            cur_vld_d = 1'b0;
            nxt_vld_d = 1'b0;
            idx_d     = '0;
            fin_d     = 1'b0;
            svld_d    = 1'b0;
            sample_d  = sample_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            cur_vld_q <= 1'b0;
            cur_rev_q <= 1'b0;
            nxt_q     <= '0;
            nxt_vld_q <= 1'b0;
            idx_q     <= '0;
            ptr_q     <= START_ADDR;
            ptr_end_q <= 1'b0;
            sample_q  <= '0;
            svld_q    <= 1'b0;
            fin_q     <= 1'b0;
            urun_q    <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            cur_vld_q <= cur_vld_d;
            cur_rev_q <= cur_rev_d;
            nxt_q     <= nxt_d;
            nxt_vld_q <= nxt_vld_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            ptr_end_q <= ptr_end_d;
            sample_q  <= sample_d;
            svld_q    <= svld_d;
            fin_q     <= fin_d;
            urun_q    <= urun_d;
        end
    end

    assign audio_sample   = sample_q;
    assign sample_valid   = svld_q;
    assign finished       = fin_q;
    assign underrun_count = urun_q;

endmodule

// File: tb/tb_audio_stream_player.sv
// Bench for audio_stream_player: behavioural flash slave, tick driver and a
// playback-order model over a four-word window.
module tb_audio_stream_player;

    localparam int SAMPLE_W = 16;
    localparam int SPW      = 2;
    localparam int ADDR_W   = 23;
    localparam int NW       = 4;
    localparam logic [ADDR_W-1:0] S_ADDR = '0;
    localparam logic [ADDR_W-1:0] E_ADDR = ADDR_W'(NW - 1);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    sample_tick = 1'b0;
    logic                    start = 1'b0;
    logic                    play = 1'b0;
    logic                    forward = 1'b1;
    logic                    loop = 1'b0;
    logic                    flash_read;
    logic [ADDR_W-1:0]       flash_addr;
    logic                    flash_waitrequest;
    logic                    flash_readdatavalid;
    logic [SAMPLE_W*SPW-1:0] flash_readdata;
    logic [SAMPLE_W-1:0]     audio_sample;
    logic                    sample_valid;
    logic                    finished;
    logic [7:0]              underrun_count;

    audio_stream_player #(
        .SAMPLE_W   (SAMPLE_W),
        .SPW        (SPW),
        .ADDR_W     (ADDR_W),
        .START_ADDR (S_ADDR),
        .END_ADDR   (E_ADDR)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sample_tick         (sample_tick),
        .start               (start),
        .play                (play),
        .forward             (forward),
        .loop                (loop),
        .flash_read          (flash_read),
        .flash_addr          (flash_addr),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdatavalid (flash_readdatavalid),
        .flash_readdata      (flash_readdata),
        .audio_sample        (audio_sample),
        .sample_valid        (sample_valid),
        .finished            (finished),
        .underrun_count      (underrun_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [SAMPLE_W*SPW-1:0] mem [NW];
    int                      cfg_wait = 0;
    int                      cfg_lat  = 0;
    int                      tick_gap = 4;
    logic                    slave_active = 1'b0;
    logic [ADDR_W-1:0]       slave_addr = '0;
    int                      slave_reqs = 0;

    logic [SAMPLE_W-1:0] got [$];
    int                  starve = 0;
    bit                  started = 1'b0;
    bit                  tick_fin = 1'b0;

    // Flash slave: waitrequest for cfg_wait cycles, data cfg_lat cycles after acceptance.
    initial begin : flash_slave
        logic [ADDR_W-1:0] a;
        flash_waitrequest   = 1'b0;
        flash_readdatavalid = 1'b0;
        flash_readdata      = '0;
        forever begin
            @(negedge clk);
            flash_readdatavalid = 1'b0;
            flash_waitrequest   = (cfg_wait != 0);
            if (flash_read && rst_n) begin
                a            = flash_addr;
                slave_addr   = a;
                slave_active = 1'b1;
                slave_reqs++;
                for (int i = 0; i < cfg_wait; i++) begin
                    flash_waitrequest = 1'b1;
                    @(negedge clk);
                    if (rst_n) begin
                        checks++;
                        if (flash_read !== 1'b1 || flash_addr !== a) begin
                            errors++;
                            $display("FAIL stall_hold: read=%0b addr=%0h, expected read=1 addr=%0h",
                                     flash_read, flash_addr, a);
                        end
                    end
                end
                flash_waitrequest = 1'b0;
                @(negedge clk);
                flash_waitrequest = (cfg_wait != 0);
                for (int i = 0; i < cfg_lat; i++) @(negedge clk);
                flash_readdata      = mem[a[1:0]];
                flash_readdatavalid = 1'b1;
                slave_active        = 1'b0;
            end
        end
    end

    // k-th sample in playback order, straight from the window contents.
    function automatic logic [SAMPLE_W-1:0] exp_sample(input bit fwd, input int k);
        int w;
        int j;
        logic [SAMPLE_W*SPW-1:0] d;
        w = (k / SPW) % NW;
        j = k % SPW;
        d = fwd ? mem[w] : mem[NW-1-w];
        return fwd ? d[j*SAMPLE_W +: SAMPLE_W] : d[(SPW-1-j)*SAMPLE_W +: SAMPLE_W];
    endfunction

    task automatic set_mem_pattern();
        for (int n = 0; n < NW; n++) mem[n] = {16'(n + 'h1000), 16'(n)};
    endtask

    task automatic set_mem_random();
        for (int n = 0; n < NW; n++) mem[n] = $urandom;
        mem[1][15:0] = ~mem[0][15:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; sample_tick = 1'b0; start = 1'b0; play = 1'b0;
        repeat (64) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_start(input bit fwd, input bit lp);
        @(negedge clk);
        forward = fwd; loop = lp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got.delete(); started = 1'b0; starve = 0;
    endtask

    task automatic tick(input bit pl);
        @(negedge clk);
        sample_tick = 1'b1; play = pl;
        @(negedge clk);
        sample_tick = 1'b0;
        tick_fin = finished;
        if (sample_valid) begin
            got.push_back(audio_sample);
            started = 1'b1;
        end else if (started && pl) begin
            starve++;
        end
        repeat (tick_gap - 2) @(negedge clk);
    endtask

    task automatic test_reset();
        int reqs0;
        do_reset();
        set_mem_pattern(); cfg_wait = 0; cfg_lat = 0; tick_gap = 4;
        do_start(1'b1, 1'b1);
        for (int t = 0; t < 8; t++) tick(1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (flash_read !== 1'b0 || flash_addr !== S_ADDR || audio_sample !== '0 ||
            sample_valid !== 1'b0 || finished !== 1'b0 || underrun_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: rd=%0b addr=%0h smp=%0h vld=%0b fin=%0b urun=%0d, expected all zero",
                     flash_read, flash_addr, audio_sample, sample_valid, finished, underrun_count);
        end
        repeat (64) @(negedge clk);
        checks++;
        if (audio_sample !== '0 || flash_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: smp=%0h rd=%0b, expected 0 0", audio_sample, flash_read);
        end
        rst_n = 1'b1;
        got.delete(); started = 1'b0;
        reqs0 = slave_reqs;
        for (int t = 0; t < 6; t++) tick(1'b1);
        checks++;
        if (got.size() != 0 || slave_reqs != reqs0) begin
            errors++;
            $display("FAIL idle_after_reset: samples=%0d reads=%0d, expected 0 0",
                     got.size(), slave_reqs - reqs0);
        end
        do_start(1'b1, 1'b1);
        for (int t = 0; t < 4; t++) tick(1'b1);
        checks++;
        if (got.size() == 0 || got[0] !== exp_sample(1'b1, 0)) begin
            errors++;
            $display("FAIL restart_after_reset: n=%0d first=%0h, expected first=%0h",
                     got.size(), (got.size() != 0) ? got[0] : 16'hxxxx, exp_sample(1'b1, 0));
        end
    endtask

    task automatic test_forward_once();
        int n0;
        do_reset();
        set_mem_pattern(); cfg_wait = 0; cfg_lat = 0; tick_gap = 4;
        do_start(1'b1, 1'b0);
        for (int t = 0; t < 12; t++) begin
            n0 = got.size();
            tick(1'b1);
            if (n0 == 7 && got.size() == 8) begin
                checks++;
                if (tick_fin !== 1'b1) begin
                    errors++;
                    $display("FAIL fin_with_last: finished=%0b, expected 1", tick_fin);
                end
            end else if (got.size() < 8) begin
                checks++;
                if (finished !== 1'b0) begin
                    errors++;
                    $display("FAIL fin_early: finished=1 after %0d samples, expected 0", got.size());
                end
            end
        end
        checks++;
        if (got.size() != 8 || finished !== 1'b1 || underrun_count !== 8'd0) begin
            errors++;
            $display("FAIL fwd_once_count: n=%0d fin=%0b urun=%0d, expected 8 1 0",
                     got.size(), finished, underrun_count);
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_sample(1'b1, i)) begin
                errors++;
                $display("FAIL fwd_once_seq[%0d]: got %0h, expected %0h", i, got[i], exp_sample(1'b1, i));
                break;
            end
        end
    endtask

    task automatic test_reverse_loop();
        do_reset();
        set_mem_pattern(); cfg_wait = 0; cfg_lat = 0; tick_gap = 4;
        do_start(1'b0, 1'b1);
        for (int t = 0; t < 21; t++) tick(1'b1);
        checks++;
        if (got.size() != 20 || underrun_count !== 8'd0 || finished !== 1'b0) begin
            errors++;
            $display("FAIL rev_loop_count: n=%0d urun=%0d fin=%0b, expected 20 0 0",
                     got.size(), underrun_count, finished);
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_sample(1'b0, i)) begin
                errors++;
                $display("FAIL rev_loop_seq[%0d]: got %0h, expected %0h", i, got[i], exp_sample(1'b0, i));
                break;
            end
        end
    endtask

    task automatic test_stall_underrun();
        int exp_u;
        do_reset();
        set_mem_random(); cfg_wait = 5; cfg_lat = 40; tick_gap = 4;
        do_start(1'b1, 1'b1);
        for (int t = 0; t < 340; t++) begin
            tick(1'b1);
            if (t == 40 || t == 339) begin
                exp_u = (starve > 255) ? 255 : starve;
                checks++;
                if (underrun_count !== 8'(exp_u)) begin
                    errors++;
                    $display("FAIL underrun_t%0d: got %0d, expected %0d", t, underrun_count, exp_u);
                end
            end
        end
        checks++;
        if (starve <= 255 || got.size() < 8) begin
            errors++;
            $display("FAIL underrun_saturate_reach: starved=%0d samples=%0d, expected >255 and >=8",
                     starve, got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_sample(1'b1, i)) begin
                errors++;
                $display("FAIL stall_seq[%0d]: got %0h, expected %0h", i, got[i], exp_sample(1'b1, i));
                break;
            end
        end
        cfg_wait = 0; cfg_lat = 0;
    endtask

    task automatic test_pause();
        int n_before;
        int pre;
        logic [SAMPLE_W-1:0] hold;
        do_reset();
        set_mem_random(); cfg_wait = 0; cfg_lat = $urandom_range(0, 2); tick_gap = 4;
        do_start(1'b1, 1'b1);
        pre = 2 * $urandom_range(1, 3) + 2;
        for (int t = 0; t < pre; t++) tick(1'b1);
        n_before = got.size();
        hold = audio_sample;
        for (int t = 0; t < 10; t++) begin
            tick(1'b0);
            checks++;
            if (got.size() != n_before || audio_sample !== hold) begin
                errors++;
                $display("FAIL pause_hold: n=%0d smp=%0h, expected n=%0d smp=%0h",
                         got.size(), audio_sample, n_before, hold);
            end
        end
        for (int t = 0; t < 7; t++) tick(1'b1);
        checks++;
        if (got.size() != n_before + 7 || (n_before % 2) != 1) begin
            errors++;
            $display("FAIL pause_resume_count: n=%0d, expected %0d (odd before pause)",
                     got.size(), n_before + 7);
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_sample(1'b1, i)) begin
                errors++;
                $display("FAIL pause_seq[%0d]: got %0h, expected %0h", i, got[i], exp_sample(1'b1, i));
                break;
            end
        end
    endtask

    task automatic test_restart_discard();
        int t;
        do_reset();
        set_mem_random(); cfg_wait = 0; cfg_lat = 20; tick_gap = 8;
        do_start(1'b1, 1'b1);
        t = 0;
        while (!(slave_active && slave_addr == ADDR_W'(1)) && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 300) begin
            errors++;
            $display("FAIL discard_wait: read of word 1 never seen within 300 cycles");
        end
        do_start(1'b1, 1'b1);
        for (int k = 0; k < 12; k++) tick(1'b1);
        checks++;
        if (got.size() < 2) begin
            errors++;
            $display("FAIL discard_count: n=%0d, expected >=2", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_sample(1'b1, i)) begin
                errors++;
                $display("FAIL discard_seq[%0d]: got %0h, expected %0h", i, got[i], exp_sample(1'b1, i));
                break;
            end
        end
        cfg_lat = 0; tick_gap = 4;
    endtask

    task automatic test_start_tick();
        do_reset();
        set_mem_random(); cfg_wait = 0; cfg_lat = 0; tick_gap = 4;
        do_start(1'b1, 1'b1);
        for (int t = 0; t < 5; t++) tick(1'b1);
        @(negedge clk);
        forward = 1'b1; start = 1'b1; sample_tick = 1'b1; play = 1'b1;
        @(negedge clk);
        start = 1'b0; sample_tick = 1'b0;
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_beats_tick: sample_valid=%0b, expected 0", sample_valid);
        end
        got.delete(); started = 1'b0;
        for (int t = 0; t < 6; t++) tick(1'b1);
        checks++;
        if (got.size() == 0 || got[0] !== exp_sample(1'b1, 0)) begin
            errors++;
            $display("FAIL start_tick_first: n=%0d first=%0h, expected first=%0h",
                     got.size(), (got.size() != 0) ? got[0] : 16'hxxxx, exp_sample(1'b1, 0));
        end
    endtask

    initial begin
        test_reset();
        test_forward_once();
        test_reverse_loop();
        test_stall_underrun();
        test_pause();
        test_restart_discard();
        test_start_tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
